// File: rtl/stream_demux.sv
// Routes one input stream to one of four single-beat registered output slots selected by in_sel.
// Latency 1 cycle; in_ready depends only on the selected slot (free or draining this cycle).
module stream_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [15:0]      beat_count
);

    logic [3:0]       vld_q, vld_d;
    logic [WIDTH-1:0] dat_q [4];
    logic [WIDTH-1:0] dat_d [4];
    logic [15:0]      cnt_q, cnt_d;
    logic             in_hs;

    // A slot draining this cycle is free, so a stream into one channel never bubbles.
    always_comb begin
        in_ready = !vld_q[in_sel] || out_ready[in_sel];
        in_hs    = in_valid && in_ready;
        vld_d    = vld_q;
        dat_d    = dat_q;
        cnt_d    = cnt_q + 16'(in_hs);
        for (int i = 0; i < 4; i++) begin
            if (vld_q[i] && out_ready[i]) begin
                vld_d[i] = 1'b0;
            end
            // Load wins over drain so a same-cycle drain+load keeps the slot full.
            if (in_hs && (in_sel == 2'(i))) begin
                vld_d[i] = 1'b1;
                dat_d[i] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid  = vld_q;
    assign out_a      = dat_q[0];
    assign out_b      = dat_q[1];
    assign out_c      = dat_q[2];
    assign out_d      = dat_q[3];
    assign beat_count = cnt_q;

endmodule

// File: tb/tb_stream_demux.sv
// Randomized and directed bench for stream_demux against a per-slot behavioural model.
module tb_stream_demux;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [7:0]  out_a, out_b, out_c, out_d;
    logic [15:0] beat_count;
    logic [7:0]  dut_dat [4];

    int errs   = 0;
    int checks = 0;

    // Behavioural model: each slot is "holding a beat or not", plus a wrapping beat tally.
    logic        m_vld [4];
    logic [7:0]  m_dat [4];
    logic [15:0] m_cnt;

    stream_demux #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d),
        .beat_count(beat_count)
    );

    assign dut_dat[0] = out_a;
    assign dut_dat[1] = out_b;
    assign dut_dat[2] = out_c;
    assign dut_dat[3] = out_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_vld[c] = 1'b0;
            m_dat[c] = 8'h00;
        end
        m_cnt = 16'h0000;
    endtask

    task automatic set_in(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // One clock edge: the model consumes the inputs present at the edge, then we move to the falling edge.
    task automatic tick();
        logic acc;
        @(posedge clk);
        acc = in_valid && (!m_vld[in_sel] || out_ready[in_sel]);
        for (int c = 0; c < 4; c++) begin
            if (m_vld[c] && out_ready[c]) m_vld[c] = 1'b0;
        end
        if (acc) begin
            m_vld[in_sel] = 1'b1;
            m_dat[in_sel] = in_data;
            m_cnt         = m_cnt + 16'd1;
        end
        @(negedge clk);
    endtask

    function automatic logic [3:0] m_vld_vec();
        return {m_vld[3], m_vld[2], m_vld[1], m_vld[0]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1'b0, 2'b00, 8'h00, 4'b0000);
        model_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 4'b0000) begin errs++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
        checks++;
        if ({out_d, out_c, out_b, out_a} !== 32'h0) begin errs++; $display("FAIL reset_data: got %h expected 0", {out_d, out_c, out_b, out_a}); end
        checks++;
        if (beat_count !== 16'h0) begin errs++; $display("FAIL reset_count: got %h expected 0", beat_count); end
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        // First edge after release must accept.
        set_in(1'b1, 2'b01, 8'h3C, 4'b0000);
        tick();
        checks++;
        if (out_valid !== 4'b0010 || out_b !== 8'h3C) begin
            errs++; $display("FAIL first_beat: got valid=%b b=%h expected valid=0010 b=3c", out_valid, out_b);
        end
        // Drain b and restart from a clean count.
        set_in(1'b0, 2'b00, 8'h00, 4'b1111);
        tick();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [7:0] pat [4];
        pat[0] = 8'hAA; pat[1] = 8'hBB; pat[2] = 8'hCC; pat[3] = 8'hDD;
        for (int c = 0; c < 4; c++) begin
            set_in(1'b1, 2'(c), pat[c], 4'b0000);
            tick();
        end
        set_in(1'b0, 2'b00, 8'h00, 4'b0000);
        checks++;
        if (out_valid !== 4'b1111) begin errs++; $display("FAIL fill_valid: got %b expected 1111", out_valid); end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (dut_dat[c] !== pat[c]) begin errs++; $display("FAIL fill_data ch%0d: got %h expected %h", c, dut_dat[c], pat[c]); end
        end
        checks++;
        if (beat_count !== 16'd4) begin errs++; $display("FAIL fill_count: got %0d expected 4", beat_count); end
    endtask

    task automatic test_backpressure();
        set_in(1'b1, 2'b01, 8'h11, 4'b0000);
        checks++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready_stalled: got %b expected 0", in_ready); end
        tick();
        checks++;
        if (out_b !== 8'hBB || out_valid[1] !== 1'b1) begin
            errs++; $display("FAIL bp_hold: got b=%h v=%b expected b=bb v=1", out_b, out_valid[1]);
        end
        set_in(1'b1, 2'b01, 8'h11, 4'b0010);
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_in_ready_drain: got %b expected 1", in_ready); end
        tick();
        set_in(1'b0, 2'b00, 8'h00, 4'b0000);
        checks++;
        if (out_b !== 8'h11 || out_valid[1] !== 1'b1) begin
            errs++; $display("FAIL bp_replace: got b=%h v=%b expected b=11 v=1", out_b, out_valid[1]);
        end
    endtask

    task automatic test_independence();
        set_in(1'b0, 2'b00, 8'h00, 4'b0100);
        tick();
        set_in(1'b1, 2'b10, 8'h5A, 4'b0000);
        checks++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL indep_in_ready: got %b expected 1", in_ready); end
        tick();
        set_in(1'b0, 2'b00, 8'h00, 4'b0000);
        checks++;
        if (out_c !== 8'h5A || out_a !== 8'hAA || out_valid[0] !== 1'b1) begin
            errs++; $display("FAIL indep_data: got c=%h a=%h va=%b expected c=5a a=aa va=1", out_c, out_a, out_valid[0]);
        end
    endtask

    task automatic test_streaming();
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b1, 2'b11, 8'(k), 4'b1111);
            checks++;
            if (in_ready !== 1'b1) begin errs++; $display("FAIL stream_stall beat%0d: got %b expected 1", k, in_ready); end
            tick();
            checks++;
            if (out_d !== 8'(k) || out_valid[3] !== 1'b1) begin
                errs++; $display("FAIL stream_out beat%0d: got d=%h v=%b expected d=%h v=1", k, out_d, out_valid[3], 8'(k));
            end
        end
        set_in(1'b0, 2'b00, 8'h00, 4'b1111);
        tick();
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int n = 0; n < 400; n++) begin
            set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
            exp_rdy = !m_vld[in_sel] || out_ready[in_sel];
            checks++;
            if (in_ready !== exp_rdy) begin errs++; $display("FAIL rand_in_ready cyc%0d: got %b expected %b", n, in_ready, exp_rdy); end
            tick();
            checks++;
            if (out_valid !== m_vld_vec()) begin errs++; $display("FAIL rand_valid cyc%0d: got %b expected %b", n, out_valid, m_vld_vec()); end
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (dut_dat[c] !== m_dat[c]) begin errs++; $display("FAIL rand_data cyc%0d ch%0d: got %h expected %h", n, c, dut_dat[c], m_dat[c]); end
            end
            checks++;
            if (beat_count !== m_cnt) begin errs++; $display("FAIL rand_count cyc%0d: got %0d expected %0d", n, beat_count, m_cnt); end
        end
        set_in(1'b0, 2'b00, 8'h00, 4'b0000);
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 2'b00, 8'h77, 4'b0000);
        tick();
        set_in(1'b1, 2'b10, 8'h99, 4'b0000);
        tick();
        set_in(1'b0, 2'b00, 8'h00, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 4'b0000 || beat_count !== 16'h0) begin
            errs++; $display("FAIL midrst_clear: got valid=%b count=%h expected 0000/0", out_valid, beat_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1'b1, 2'($urandom_range(0, 3)), 8'h42, 4'b0000);
        tick();
        set_in(1'b0, 2'b00, 8'h00, 4'b0000);
        checks++;
        if ($countones(out_valid) != 1 || beat_count !== 16'd1) begin
            errs++; $display("FAIL midrst_after: got valid=%b count=%0d expected one bit/1", out_valid, beat_count);
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        set_in(1'b1, 2'b00, 8'h00, 4'b1111);
        for (int k = 0; k < 65535; k++) begin
            in_sel  = 2'(k);
            in_data = 8'(k);
            tick();
        end
        checks++;
        if (beat_count !== 16'hFFFF) begin errs++; $display("FAIL wrap_full: got %h expected ffff", beat_count); end
        tick();
        set_in(1'b0, 2'b00, 8'h00, 4'b1111);
        checks++;
        if (beat_count !== 16'h0000) begin errs++; $display("FAIL wrap_zero: got %h expected 0000", beat_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_independence();
        test_streaming();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
